// File: rtl/dmac_ctrl_arbiter.sv
// N-to-1 control-port concentrator for the DMA control target: lock-until-grant
// round-robin arbitration with an ordered response FIFO routing replies back.
module dmac_ctrl_arbiter #(
    parameter int NB_CTRLS        = 4,
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int BE_WIDTH        = DATA_WIDTH / 8,
    parameter int PE_ID_WIDTH     = 1,
    parameter int RESP_FIFO_DEPTH = 4
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic [NB_CTRLS-1:0]               s_req_i,
    input  logic [NB_CTRLS*ADDR_WIDTH-1:0]    s_add_i,
    input  logic [NB_CTRLS-1:0]               s_wen_i,
    input  logic [NB_CTRLS*BE_WIDTH-1:0]      s_be_i,
    input  logic [NB_CTRLS*DATA_WIDTH-1:0]    s_wdata_i,
    input  logic [NB_CTRLS*PE_ID_WIDTH-1:0]   s_id_i,
    output logic [NB_CTRLS-1:0]               s_gnt_o,
    output logic [NB_CTRLS-1:0]               s_r_valid_o,
    output logic [DATA_WIDTH-1:0]             s_r_rdata_o,
    output logic                              s_r_opc_o,
    output logic [PE_ID_WIDTH-1:0]            s_r_id_o,
    output logic                              m_req_o,
    output logic [ADDR_WIDTH-1:0]             m_add_o,
    output logic                              m_wen_o,
    output logic [BE_WIDTH-1:0]               m_be_o,
    output logic [DATA_WIDTH-1:0]             m_wdata_o,
    output logic [PE_ID_WIDTH-1:0]            m_id_o,
    input  logic                              m_gnt_i,
    input  logic                              m_r_valid_i,
    input  logic [DATA_WIDTH-1:0]             m_r_rdata_i,
    input  logic                              m_r_opc_i,
    output logic [NB_CTRLS-1:0]               pending_o,
    output logic                              err_o
);
    localparam int IDX_W = $clog2(NB_CTRLS);
    localparam int PTR_W = $clog2(RESP_FIFO_DEPTH);
    localparam int CNT_W = $clog2(RESP_FIFO_DEPTH + 1);

    logic [IDX_W-1:0]       rr_ptr_reg;
    logic                   lock_reg;
    logic [IDX_W-1:0]       lock_idx_reg;
    logic [IDX_W-1:0]       rr_sel;
    logic [IDX_W-1:0]       sel;
    logic                   lock_active;
    logic                   full;
    logic                   empty;
    logic                   push;
    logic                   pop;

    logic [IDX_W-1:0]       fifo_port_mem [RESP_FIFO_DEPTH];
    logic [PE_ID_WIDTH-1:0] fifo_id_mem   [RESP_FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr_reg;
    logic [PTR_W-1:0]       rd_ptr_reg;
    logic [CNT_W-1:0]       count_reg;
    logic [IDX_W-1:0]       head_port;

    logic [NB_CTRLS-1:0]    r_valid_reg;
    logic [DATA_WIDTH-1:0]  r_rdata_reg;
    logic                   r_opc_reg;
    logic [PE_ID_WIDTH-1:0] r_id_reg;
    logic                   err_reg;

    // Scanning from the highest offset down lets the lowest offset win.
    always_comb begin
        int idx;
        idx    = 0;
        rr_sel = rr_ptr_reg;
        for (int i = NB_CTRLS - 1; i >= 0; i--) begin
            idx = int'(rr_ptr_reg) + i;
            if (idx >= NB_CTRLS) idx = idx - NB_CTRLS;
            if (s_req_i[idx]) rr_sel = IDX_W'(idx);
        end
    end

    // A lock only counts while the locked port still requests, so a dropped
    // request can never be granted on behalf of another port.
    assign lock_active = lock_reg & s_req_i[lock_idx_reg];
    assign sel         = lock_active ? lock_idx_reg : rr_sel;

    assign full    = (count_reg == CNT_W'(RESP_FIFO_DEPTH));
    assign empty   = (count_reg == '0);
    assign m_req_o = (|s_req_i) & ~full;
    assign push    = m_req_o & m_gnt_i;
    assign pop     = m_r_valid_i & ~empty;

    assign m_add_o   = s_add_i[sel*ADDR_WIDTH +: ADDR_WIDTH];
    assign m_wen_o   = s_wen_i[sel];
    assign m_be_o    = s_be_i[sel*BE_WIDTH +: BE_WIDTH];
    assign m_wdata_o = s_wdata_i[sel*DATA_WIDTH +: DATA_WIDTH];
    assign m_id_o    = s_id_i[sel*PE_ID_WIDTH +: PE_ID_WIDTH];

    assign head_port = fifo_port_mem[rd_ptr_reg];

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_port_mem[wr_ptr_reg] <= sel;
            fifo_id_mem[wr_ptr_reg]   <= m_id_o;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rr_ptr_reg   <= '0;
            lock_reg     <= 1'b0;
            lock_idx_reg <= '0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            r_valid_reg  <= '0;
            r_rdata_reg  <= '0;
            r_opc_reg    <= 1'b0;
            r_id_reg     <= '0;
            err_reg      <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
                rr_ptr_reg <= (sel == IDX_W'(NB_CTRLS - 1)) ? '0 : sel + IDX_W'(1);
                lock_reg   <= 1'b0;
            end else if (m_req_o) begin
                lock_reg     <= 1'b1;
                lock_idx_reg <= sel;
            end else begin
                lock_reg <= 1'b0;
            end

            r_valid_reg <= '0;
            if (pop) begin
                rd_ptr_reg             <= rd_ptr_reg + PTR_W'(1);
                r_valid_reg[head_port] <= 1'b1;
                r_rdata_reg            <= m_r_rdata_i;
                r_opc_reg              <= m_r_opc_i;
                r_id_reg               <= fifo_id_mem[rd_ptr_reg];
            end

            if (push && !pop)      count_reg <= count_reg + CNT_W'(1);
            else if (!push && pop) count_reg <= count_reg - CNT_W'(1);

            if (m_r_valid_i && empty) err_reg <= 1'b1;
        end
    end

    // Per-port outstanding counters; bounded by the FIFO depth so they never wrap.
    for (genvar gi = 0; gi < NB_CTRLS; gi++) begin : g_port
        logic             inc;
        logic             dec;
        logic [CNT_W-1:0] cnt_reg;

        assign inc = push & (sel == IDX_W'(gi));
        assign dec = pop & (head_port == IDX_W'(gi));

        always_ff @(posedge clk_i) begin
            if (!rst_ni)           cnt_reg <= '0;
            else if (inc && !dec)  cnt_reg <= cnt_reg + CNT_W'(1);
            else if (dec && !inc)  cnt_reg <= cnt_reg - CNT_W'(1);
        end

        assign s_gnt_o[gi]   = inc;
        assign pending_o[gi] = (cnt_reg != '0);
    end

    assign s_r_valid_o = r_valid_reg;
    assign s_r_rdata_o = r_rdata_reg;
    assign s_r_opc_o   = r_opc_reg;
    assign s_r_id_o    = r_id_reg;
    assign err_o       = err_reg;
endmodule

// File: tb/tb_dmac_ctrl_arbiter.sv
// Directed bench for dmac_ctrl_arbiter: reset, round-robin order, lock, FIFO full,
// same-cycle push/pop and the sticky error flag.
module tb_dmac_ctrl_arbiter;
    localparam int NB = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = 4;
    localparam int IW = 1;

    logic              clk_i = 1'b0;
    logic              rst_ni;
    logic [NB-1:0]     s_req_i;
    logic [NB*AW-1:0]  s_add_i;
    logic [NB-1:0]     s_wen_i;
    logic [NB*BW-1:0]  s_be_i;
    logic [NB*DW-1:0]  s_wdata_i;
    logic [NB*IW-1:0]  s_id_i;
    logic [NB-1:0]     s_gnt_o;
    logic [NB-1:0]     s_r_valid_o;
    logic [DW-1:0]     s_r_rdata_o;
    logic              s_r_opc_o;
    logic [IW-1:0]     s_r_id_o;
    logic              m_req_o;
    logic [AW-1:0]     m_add_o;
    logic              m_wen_o;
    logic [BW-1:0]     m_be_o;
    logic [DW-1:0]     m_wdata_o;
    logic [IW-1:0]     m_id_o;
    logic              m_gnt_i;
    logic              m_r_valid_i;
    logic [DW-1:0]     m_r_rdata_i;
    logic              m_r_opc_i;
    logic [NB-1:0]     pending_o;
    logic              err_o;

    int checks   = 0;
    int failures = 0;

    dmac_ctrl_arbiter dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .s_req_i     (s_req_i),
        .s_add_i     (s_add_i),
        .s_wen_i     (s_wen_i),
        .s_be_i      (s_be_i),
        .s_wdata_i   (s_wdata_i),
        .s_id_i      (s_id_i),
        .s_gnt_o     (s_gnt_o),
        .s_r_valid_o (s_r_valid_o),
        .s_r_rdata_o (s_r_rdata_o),
        .s_r_opc_o   (s_r_opc_o),
        .s_r_id_o    (s_r_id_o),
        .m_req_o     (m_req_o),
        .m_add_o     (m_add_o),
        .m_wen_o     (m_wen_o),
        .m_be_o      (m_be_o),
        .m_wdata_o   (m_wdata_o),
        .m_id_o      (m_id_o),
        .m_gnt_i     (m_gnt_i),
        .m_r_valid_i (m_r_valid_i),
        .m_r_rdata_i (m_r_rdata_i),
        .m_r_opc_i   (m_r_opc_i),
        .pending_o   (pending_o),
        .err_o       (err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] addr_of(input int k);
        return 32'h1000_0000 + 32'(k) * 32'h10;
    endfunction

    function automatic logic [31:0] wdata_of(input int k);
        return 32'hD000_0000 + 32'(k);
    endfunction

    initial begin
        rst_ni      = 1'b0;
        s_req_i     = '0;
        m_gnt_i     = 1'b0;
        m_r_valid_i = 1'b0;
        m_r_rdata_i = '0;
        m_r_opc_i   = 1'b0;
        for (int k = 0; k < NB; k++) begin
            s_add_i[k*AW +: AW]   = addr_of(k);
            s_wdata_i[k*DW +: DW] = wdata_of(k);
            s_be_i[k*BW +: BW]    = 4'(k + 1);
            s_wen_i[k]            = 1'(k % 2);
            s_id_i[k*IW +: IW]    = 1'(k % 2);
        end

        // Reset then idle
        tick();
        tick();
        rst_ni = 1'b1;
        settle();
        chk("reset_rvalid", 32'(s_r_valid_o), 32'h0);
        chk("reset_rdata",  32'(s_r_rdata_o), 32'h0);
        chk("reset_opc",    32'(s_r_opc_o),   32'h0);
        chk("reset_rid",    32'(s_r_id_o),    32'h0);
        chk("reset_err",    32'(err_o),       32'h0);
        chk("reset_pend",   32'(pending_o),   32'h0);
        chk("reset_mreq",   32'(m_req_o),     32'h0);
        chk("reset_gnt",    32'(s_gnt_o),     32'h0);
        tick();

        // All ports request, grant held high, responses two cycles after grant
        m_gnt_i = 1'b1;
        for (int j = 0; j < 12; j++) begin
            int n;
            s_req_i     = (j < 8) ? 4'hF : 4'h0;
            m_r_valid_i = (j >= 2 && j < 10);
            m_r_rdata_i = 32'h5000 + 32'(j - 2);
            m_r_opc_i   = (j >= 2) ? 1'(((j - 2) / 2) % 2) : 1'b0;
            settle();
            if (j < 8) begin
                chk("rr_gnt", 32'(s_gnt_o), 32'(1 << (j % 4)));
                chk("rr_add", m_add_o, addr_of(j % 4));
            end else begin
                chk("rr_idle_req", 32'(m_req_o), 32'h0);
            end
            if (j >= 3 && j <= 10) begin
                n = j - 3;
                chk("rr_rvalid", 32'(s_r_valid_o), 32'(1 << (n % 4)));
                chk("rr_rid",    32'(s_r_id_o),    32'(n % 2));
                chk("rr_rdata",  s_r_rdata_o,      32'h5000 + 32'(n));
                chk("rr_opc",    32'(s_r_opc_o),   32'((n / 2) % 2));
            end else begin
                chk("rr_rvalid_idle", 32'(s_r_valid_o), 32'h0);
            end
            tick();
        end

        // Lock: port 2 stalls for three cycles while port 0 joins
        m_gnt_i = 1'b0;
        m_r_valid_i = 1'b0;
        s_req_i = 4'b0100;
        settle();
        chk("lock_req0", 32'(m_req_o), 32'h1);
        chk("lock_add0", m_add_o, addr_of(2));
        chk("lock_gnt0", 32'(s_gnt_o), 32'h0);
        tick();
        s_req_i = 4'b0101;
        settle();
        chk("lock_add1", m_add_o, addr_of(2));
        tick();
        settle();
        chk("lock_add2", m_add_o, addr_of(2));
        chk("lock_wdata", m_wdata_o, wdata_of(2));
        chk("lock_be",    32'(m_be_o), 32'h3);
        chk("lock_wen",   32'(m_wen_o), 32'h0);
        tick();
        m_gnt_i = 1'b1;
        settle();
        chk("lock_gnt_p2", 32'(s_gnt_o), 32'b0100);
        tick();
        s_req_i = 4'b0001;
        settle();
        chk("lock_gnt_p0", 32'(s_gnt_o), 32'b0001);
        chk("lock_add_p0", m_add_o, addr_of(0));
        tick();
        s_req_i     = 4'b0000;
        m_gnt_i     = 1'b0;
        m_r_valid_i = 1'b1;
        m_r_rdata_i = 32'h77;
        m_r_opc_i   = 1'b1;
        settle();
        chk("lock_pend", 32'(pending_o), 32'b0101);
        tick();
        m_r_rdata_i = 32'h88;
        m_r_opc_i   = 1'b0;
        settle();
        chk("lock_rsp0_valid", 32'(s_r_valid_o), 32'b0100);
        chk("lock_rsp0_data",  s_r_rdata_o, 32'h77);
        chk("lock_rsp0_opc",   32'(s_r_opc_o), 32'h1);
        tick();
        m_r_valid_i = 1'b0;
        settle();
        chk("lock_rsp1_valid", 32'(s_r_valid_o), 32'b0001);
        chk("lock_rsp1_data",  s_r_rdata_o, 32'h88);
        chk("lock_pend_done",  32'(pending_o), 32'h0);
        tick();

        // FIFO full: ports 1 and 3 request back to back with no responses
        s_req_i = 4'b1010;
        m_gnt_i = 1'b1;
        for (int j = 0; j < 4; j++) begin
            settle();
            chk("full_req", 32'(m_req_o), 32'h1);
            chk("full_gnt", 32'(s_gnt_o), (j % 2 == 0) ? 32'b0010 : 32'b1000);
            tick();
        end
        m_r_valid_i = 1'b1;
        m_r_rdata_i = 32'h99;
        m_r_opc_i   = 1'b0;
        settle();
        chk("full_block_req", 32'(m_req_o), 32'h0);
        chk("full_block_gnt", 32'(s_gnt_o), 32'h0);
        chk("full_pend",      32'(pending_o), 32'b1010);
        tick();
        m_r_valid_i = 1'b0;
        settle();
        chk("full_reopen_req", 32'(m_req_o), 32'h1);
        chk("full_reopen_gnt", 32'(s_gnt_o), 32'b0010);
        chk("full_rsp_valid",  32'(s_r_valid_o), 32'b0010);
        chk("full_rsp_id",     32'(s_r_id_o), 32'h1);
        chk("full_rsp_data",   s_r_rdata_o, 32'h99);
        tick();
        s_req_i = 4'b0000;
        m_gnt_i = 1'b0;
        for (int d = 0; d < 5; d++) begin
            m_r_valid_i = (d < 4);
            m_r_rdata_i = 32'hA0 + 32'(d);
            settle();
            if (d > 0) begin
                chk("drain_valid", 32'(s_r_valid_o), ((d - 1) % 2 == 0) ? 32'b1000 : 32'b0010);
                chk("drain_data",  s_r_rdata_o, 32'hA0 + 32'(d - 1));
            end
            if (d == 4) chk("drain_pend", 32'(pending_o), 32'h0);
            tick();
        end

        // Same-cycle push and pop for port 1 with one outstanding
        s_req_i     = 4'b0010;
        m_gnt_i     = 1'b1;
        m_r_valid_i = 1'b0;
        settle();
        chk("pp_gnt0", 32'(s_gnt_o), 32'b0010);
        tick();
        m_r_valid_i = 1'b1;
        m_r_rdata_i = 32'hB1;
        settle();
        chk("pp_pend_before", 32'(pending_o), 32'b0010);
        chk("pp_gnt1",        32'(s_gnt_o),   32'b0010);
        tick();
        s_req_i     = 4'b0000;
        m_gnt_i     = 1'b0;
        m_r_valid_i = 1'b0;
        settle();
        chk("pp_pend_after", 32'(pending_o),   32'b0010);
        chk("pp_rvalid",     32'(s_r_valid_o), 32'b0010);
        chk("pp_rdata",      s_r_rdata_o,      32'hB1);
        tick();
        m_r_valid_i = 1'b1;
        m_r_rdata_i = 32'hB2;
        settle();
        tick();
        m_r_valid_i = 1'b0;
        settle();
        chk("pp_rvalid2", 32'(s_r_valid_o), 32'b0010);
        chk("pp_rdata2",  s_r_rdata_o,      32'hB2);
        chk("pp_pend_end", 32'(pending_o),  32'h0);
        tick();

        // Response with empty FIFO sets a sticky error
        m_r_valid_i = 1'b1;
        m_r_rdata_i = 32'hEE;
        m_r_opc_i   = 1'b1;
        settle();
        chk("err_before", 32'(err_o), 32'h0);
        tick();
        m_r_valid_i = 1'b0;
        m_r_opc_i   = 1'b0;
        settle();
        chk("err_set",        32'(err_o),       32'h1);
        chk("err_no_rvalid",  32'(s_r_valid_o), 32'h0);
        chk("err_data_hold",  s_r_rdata_o,      32'hB2);
        tick();
        settle();
        chk("err_sticky", 32'(err_o), 32'h1);
        tick();
        rst_ni = 1'b0;
        settle();
        chk("err_pre_reset", 32'(err_o), 32'h1);
        tick();
        rst_ni = 1'b1;
        settle();
        chk("err_cleared",     32'(err_o),       32'h0);
        chk("err_reset_rdata", s_r_rdata_o,      32'h0);
        chk("err_reset_pend",  32'(pending_o),   32'h0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
